// File: rtl/axis_video_pkg.sv
// Shared types for the AXI4-Stream video pattern generator.
//   state_e   : frame sequencer states
//   pattern_e : test pattern selected at each frame start
//   clog2_min1: counter width helper that never returns zero
package axis_video_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RAMP    = 2'd0,
    RASTER  = 2'd1,
    CHECKER = 2'd2,
    CONST   = 2'd3
  } pattern_e;

  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus between the pattern generator and its consumer.
//   tdata  : packed pixel, TDATA_WIDTH bits
//   tvalid : beat valid (source)
//   tready : consumer ready (sink)
//   tuser  : start of frame
//   tlast  : end of line
interface axis_video_pattern_gen_if #(
  parameter int TDATA_WIDTH = 8
);

  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/axis_video_pattern_pixel.sv
// Combinational pixel function for one channel of the pattern generator.
//   mode      : pattern select (ramp, raster index, checkerboard, constant)
//   x, y      : pixel coordinates
//   idx       : raster index y*W+x, supplied by an incrementing counter
//   const_val : constant-mode value
//   channel   : channel number added to the ramp and raster patterns
//   pixel     : DATA_WIDTH result, arithmetic modulo 2^DATA_WIDTH
module axis_video_pattern_pixel
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int IDX_W      = 8,
  parameter int CH_W       = 1
) (
  input  pattern_e              mode,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] const_val,
  input  logic [CH_W-1:0]       channel,
  output logic [DATA_WIDTH-1:0] pixel
);

  // Operands are truncated/extended to DATA_WIDTH before adding; the
  // modulo-2^DATA_WIDTH result is the same either way.
  always_comb begin
    pixel = '0;
    case (mode)
      RAMP:    pixel = DATA_WIDTH'(x) + DATA_WIDTH'(y) + DATA_WIDTH'(channel);
      RASTER:  pixel = DATA_WIDTH'(idx) + DATA_WIDTH'(channel);
      CHECKER: pixel = {DATA_WIDTH{x[0] ^ y[0]}};
      CONST:   pixel = const_val;
      default: pixel = '0;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source.
//   i_clk, i_aresetn : rising-edge clock, asynchronous active-low reset
//   i_enable         : run request; checked only at frame boundaries
//   i_mode, i_const  : pattern select and constant value, latched per frame
//   m_axis           : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   o_frame_cnt      : completed frames, wrapping at 2^16
//   o_busy           : high whenever the sequencer is not idle
// All outputs are registered. The output register holds the beat at the
// coordinates in x_q/y_q; a new beat is loaded on every transfer (or at the
// end of a blanking interval) so lines stream without bubbles.
module axis_video_pattern_gen
  import axis_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int IMG_WIDTH  = 12,
  parameter int IMG_HEIGHT = 12,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_aresetn,
  input  logic                      i_enable,
  input  logic [1:0]                i_mode,
  input  logic [DATA_WIDTH-1:0]     i_const,
  axis_video_pattern_gen_if.master  m_axis,
  output logic [15:0]               o_frame_cnt,
  output logic                      o_busy
);

  localparam int TW        = CHANNELS * DATA_WIDTH;
  localparam int X_W       = clog2_min1(IMG_WIDTH);
  localparam int Y_W       = clog2_min1(IMG_HEIGHT);
  localparam int IDX_W     = clog2_min1(IMG_WIDTH * IMG_HEIGHT);
  localparam int CH_W      = clog2_min1(CHANNELS);
  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int B_W       = clog2_min1(BLANK_MAX);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);
  localparam logic [B_W-1:0] H_LAST = B_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [B_W-1:0] V_LAST = B_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  state_e                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [B_W-1:0]          blank_q, blank_d;
  pattern_e                mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   const_q, const_d;
  logic [15:0]             frame_q, frame_d;
  logic [TW-1:0]           tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tuser_q, tuser_d;
  logic                    tlast_q, tlast_d;
  logic                    busy_q, busy_d;

  logic                    load;        // register the pixel at (x_d, y_d)
  logic                    drop_valid;  // enter a gap (blanking or idle)
  logic                    frame_end;
  logic                    xfer;
  logic [TW-1:0]           pix_data;

  // Pixel function evaluated at the next coordinates and next latched pattern
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [CH_W-1:0] CH = CH_W'(c);
    axis_video_pattern_pixel #(
      .DATA_WIDTH (DATA_WIDTH),
      .X_W        (X_W),
      .Y_W        (Y_W),
      .IDX_W      (IDX_W),
      .CH_W       (CH_W)
    ) u_pixel (
      .mode      (mode_d),
      .x         (x_d),
      .y         (y_d),
      .idx       (idx_d),
      .const_val (const_d),
      .channel   (CH),
      .pixel     (pix_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    blank_d    = blank_q;
    mode_d     = mode_q;
    const_d    = const_q;
    frame_d    = frame_q;
    load       = 1'b0;
    drop_valid = 1'b0;
    frame_end  = 1'b0;
    xfer       = tvalid_q & m_axis.tready;

    case (state_q)
      IDLE: begin
        if (i_enable) begin
          mode_d  = pattern_e'(i_mode);
          const_d = i_const;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!tvalid_q) begin
          // Only reached on the cycle after leaving IDLE.
          load = 1'b1;
        end else if (xfer) begin
          if (x_q != X_LAST) begin
            x_d   = x_q + 1'b1;
            idx_d = idx_q + 1'b1;
            load  = 1'b1;
          end else if (y_q != Y_LAST) begin
            x_d   = '0;
            y_d   = y_q + 1'b1;
            idx_d = idx_q + 1'b1;
            if (H_BLANK > 0) begin
              state_d    = HBLANK;
              blank_d    = '0;
              drop_valid = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            frame_d = frame_q + 16'd1;
            if (V_BLANK > 0) begin
              state_d    = VBLANK;
              blank_d    = '0;
              drop_valid = 1'b1;
            end else begin
              frame_end = 1'b1;
            end
          end
        end
      end
      HBLANK: begin
        // The first pixel of the next line is loaded on the last blank
        // cycle so exactly H_BLANK cycles show tvalid low.
        if (blank_q == H_LAST) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      VBLANK: begin
        if (blank_q == V_LAST) begin
          frame_end = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame boundary: restart seamlessly while enabled, otherwise park.
    if (frame_end) begin
      if (i_enable) begin
        mode_d  = pattern_e'(i_mode);
        const_d = i_const;
        x_d     = '0;
        y_d     = '0;
        idx_d   = '0;
        state_d = ACTIVE;
        load    = 1'b1;
      end else begin
        state_d    = IDLE;
        drop_valid = 1'b1;
      end
    end
  end

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (load) begin
      tdata_d  = pix_data;
      tvalid_d = 1'b1;
      tuser_d  = (x_d == '0) && (y_d == '0);
      tlast_d  = (x_d == X_LAST);
    end else if (drop_valid) begin
      tvalid_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      blank_q  <= '0;
      mode_q   <= RAMP;
      const_q  <= '0;
      frame_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      blank_q  <= blank_d;
      mode_q   <= mode_d;
      const_q  <= const_d;
      frame_q  <= frame_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign o_frame_cnt   = frame_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
module tb_axis_video_pattern_gen;

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
  } vec_t;

  typedef struct {
    int mode;
    int cval;
    int rdy;
    int junk;
    int exp_cnt;
  } ftab_t;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  // Small instance: 4x3, blanking 2/5, one channel
  logic        s_rst_n, s_enable, s_tready;
  logic [1:0]  s_mode;
  logic [7:0]  s_const;
  logic [15:0] s_frame_cnt;
  logic        s_busy;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tuser, s_tlast;

  // Large instance: 12x12, no blanking, two channels
  logic        l_rst_n, l_enable, l_tready;
  logic [1:0]  l_mode;
  logic [7:0]  l_const;
  logic [15:0] l_frame_cnt;
  logic        l_busy;
  logic [15:0] l_tdata;
  logic        l_tvalid, l_tuser, l_tlast;

  axis_video_pattern_gen_if #(.TDATA_WIDTH(8))  s_axis ();
  axis_video_pattern_gen_if #(.TDATA_WIDTH(16)) l_axis ();

  assign s_axis.tready = s_tready;
  assign s_tdata  = s_axis.tdata;
  assign s_tvalid = s_axis.tvalid;
  assign s_tuser  = s_axis.tuser;
  assign s_tlast  = s_axis.tlast;
  assign l_axis.tready = l_tready;
  assign l_tdata  = l_axis.tdata;
  assign l_tvalid = l_axis.tvalid;
  assign l_tuser  = l_axis.tuser;
  assign l_tlast  = l_axis.tlast;

  axis_video_pattern_gen #(
    .DATA_WIDTH(8), .CHANNELS(1), .IMG_WIDTH(4), .IMG_HEIGHT(3), .H_BLANK(2), .V_BLANK(5)
  ) dut_s (
    .i_clk(clk), .i_aresetn(s_rst_n), .i_enable(s_enable), .i_mode(s_mode),
    .i_const(s_const), .m_axis(s_axis), .o_frame_cnt(s_frame_cnt), .o_busy(s_busy)
  );

  axis_video_pattern_gen #(
    .DATA_WIDTH(8), .CHANNELS(2), .IMG_WIDTH(12), .IMG_HEIGHT(12), .H_BLANK(0), .V_BLANK(0)
  ) dut_l (
    .i_clk(clk), .i_aresetn(l_rst_n), .i_enable(l_enable), .i_mode(l_mode),
    .i_const(l_const), .m_axis(l_axis), .o_frame_cnt(l_frame_cnt), .o_busy(l_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  beat_t q_s[$];
  beat_t q_l[$];
  int    gaps[$];
  int    s_beats = 0, l_beats = 0, s_gap = 0;
  bit    s_seen = 0, l_mon = 1, l_prev_stall = 0;
  int    l_rdy_mode = 0;  // 0 ready high, 1 random, 2 ready low
  beat_t s_exp, l_exp, l_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix8(int mode, int cval, int x, int y, int w, int c);
    case (mode)
      0:       return 8'(x + y + c);
      1:       return 8'(y * w + x + c);
      2:       return (((x ^ y) & 1) != 0) ? 8'hFF : 8'h00;
      default: return 8'(cval);
    endcase
  endfunction

  task automatic push_frame_s(input int mode, input int cval);
    beat_t b;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) begin
        b.data = 16'(pix8(mode, cval, x, y, 4, 0));
        b.user = (x == 0 && y == 0);
        b.last = (x == 3);
        q_s.push_back(b);
      end
  endtask

  task automatic push_frame_l(input int mode, input int cval);
    beat_t b;
    for (int y = 0; y < 12; y++)
      for (int x = 0; x < 12; x++) begin
        b.data = {pix8(mode, cval, x, y, 12, 1), pix8(mode, cval, x, y, 12, 0)};
        b.user = (x == 0 && y == 0);
        b.last = (x == 11);
        q_l.push_back(b);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_s_busy(input string name);
    int n = 0;
    while (!s_busy && n < 20) begin tick(); n++; end
    check(name, 32'(s_busy), 32'd1);
  endtask

  task automatic wait_s_idle(input string name);
    int n = 0;
    while (s_busy && n < 500) begin tick(); n++; end
    check(name, 32'(s_busy), 32'd0);
  endtask

  task automatic wait_s_cnt(input string name, input int target);
    int n = 0;
    while (32'(s_frame_cnt) != target && n < 500) begin tick(); n++; end
    check(name, 32'(s_frame_cnt), 32'(target));
  endtask

  task automatic wait_l_busy(input string name);
    int n = 0;
    while (!l_busy && n < 20) begin tick(); n++; end
    check(name, 32'(l_busy), 32'd1);
  endtask

  task automatic wait_l_idle(input string name);
    int n = 0;
    while (l_busy && n < 3000) begin tick(); n++; end
    check(name, 32'(l_busy), 32'd0);
  endtask

  task automatic wait_l_beats(input string name, input int target);
    int n = 0;
    while (l_beats < target && n < 3000) begin tick(); n++; end
    check(name, 32'(l_beats >= target), 32'd1);
  endtask

  task automatic wait_l_cnt(input string name, input int target);
    int n = 0;
    while (32'(l_frame_cnt) != target && n < 3000) begin tick(); n++; end
    check(name, 32'(l_frame_cnt), 32'(target));
  endtask

  // Ready driver for the large instance
  initial begin
    l_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (l_rdy_mode)
        0:       l_tready = 1'b1;
        1:       l_tready = 1'($urandom_range(0, 1));
        default: l_tready = 1'b0;
      endcase
    end
  end

  // Scoreboard and gap monitor, small instance
  always @(negedge clk) begin
    if (s_tvalid && s_tready) begin
      s_beats++;
      if (q_s.size() == 0) begin
        check("s_unexpected_beat", 32'd1, 32'd0);
      end else begin
        s_exp = q_s.pop_front();
        check("s_tdata", 32'(s_tdata), 32'(s_exp.data));
        check("s_tuser", 32'(s_tuser), 32'(s_exp.user));
        check("s_tlast", 32'(s_tlast), 32'(s_exp.last));
      end
    end
    if (s_tvalid) begin
      if (s_seen && s_gap > 0) gaps.push_back(s_gap);
      s_gap  = 0;
      s_seen = 1;
    end else if (s_seen && s_busy) begin
      s_gap++;
    end
  end

  // Scoreboard and stall-stability monitor, large instance
  always @(negedge clk) begin
    if (l_mon) begin
      if (l_prev_stall) begin
        check("l_stall_tvalid", 32'(l_tvalid), 32'd1);
        check("l_stall_tdata",  32'(l_tdata),  32'(l_hold.data));
        check("l_stall_tuser",  32'(l_tuser),  32'(l_hold.user));
        check("l_stall_tlast",  32'(l_tlast),  32'(l_hold.last));
      end
      if (l_tvalid && l_tready) begin
        l_beats++;
        if (q_l.size() == 0) begin
          check("l_unexpected_beat", 32'd1, 32'd0);
        end else begin
          l_exp = q_l.pop_front();
          check("l_tdata", 32'(l_tdata), 32'(l_exp.data));
          check("l_tuser", 32'(l_tuser), 32'(l_exp.user));
          check("l_tlast", 32'(l_tlast), 32'(l_exp.last));
        end
      end
      l_prev_stall = l_tvalid && !l_tready;
      l_hold.data  = l_tdata;
      l_hold.user  = l_tuser;
      l_hold.last  = l_tlast;
    end else begin
      l_prev_stall = 0;
    end
  end

  vec_t  t1[12];
  ftab_t ftab[4];
  int    base;
  int    exp_gaps[5];

  initial begin
    t1 = '{'{8'd0, 1'b1, 1'b0}, '{8'd1, 1'b0, 1'b0}, '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b1},
           '{8'd1, 1'b0, 1'b0}, '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b0}, '{8'd4, 1'b0, 1'b1},
           '{8'd2, 1'b0, 1'b0}, '{8'd3, 1'b0, 1'b0}, '{8'd4, 1'b0, 1'b0}, '{8'd5, 1'b0, 1'b1}};
    // mode, const, ready mode, mode/const written mid-frame, expected frame count
    ftab = '{'{1, 0, 1, 0, 1}, '{0, 0, 1, 3, 2}, '{2, 0, 0, 1, 3}, '{3, 8'hC3, 1, 0, 4}};
    exp_gaps = '{2, 2, 5, 2, 2};

    s_rst_n = 0; l_rst_n = 0;
    s_enable = 0; l_enable = 0;
    s_mode = 0; l_mode = 0; s_const = 0; l_const = 0;
    s_tready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_l_tvalid", 32'(l_tvalid), 32'd0);
    check("rst_l_tdata",  32'(l_tdata),  32'd0);
    check("rst_l_tuser",  32'(l_tuser),  32'd0);
    check("rst_l_tlast",  32'(l_tlast),  32'd0);
    check("rst_l_cnt",    32'(l_frame_cnt), 32'd0);
    check("rst_l_busy",   32'(l_busy),   32'd0);
    check("rst_s_tvalid", 32'(s_tvalid), 32'd0);
    check("rst_s_busy",   32'(s_busy),   32'd0);
    s_rst_n = 1; l_rst_n = 1;
    tick(); tick();
    check("idle_l_tvalid", 32'(l_tvalid), 32'd0);

    // 4x3 ramp frame from the literal table, with start latency
    for (int i = 0; i < 12; i++) begin
      s_exp.data = 16'(t1[i].data);
      s_exp.user = t1[i].user;
      s_exp.last = t1[i].last;
      q_s.push_back(s_exp);
    end
    s_mode = 0;
    s_enable = 1;
    tick();
    check("lat_busy_after_latch", 32'(s_busy), 32'd1);
    check("lat_tvalid_after_latch", 32'(s_tvalid), 32'd0);
    tick();
    check("lat_tvalid_next", 32'(s_tvalid), 32'd1);
    check("lat_tuser_next", 32'(s_tuser), 32'd1);
    s_enable = 0;
    wait_s_idle("t1_idle");
    check("t1_beats", 32'(s_beats), 32'd12);
    check("t1_frame_cnt", 32'(s_frame_cnt), 32'd1);
    check("t1_queue_left", 32'(q_s.size()), 32'd0);

    // Blanking: two checkerboard frames back to back
    s_seen = 0; s_gap = 0; gaps.delete(); s_beats = 0;
    push_frame_s(2, 0);
    push_frame_s(2, 0);
    s_mode = 2;
    s_enable = 1;
    wait_s_cnt("blank_cnt_3", 3);
    s_enable = 0;
    wait_s_idle("blank_idle");
    check("blank_beats", 32'(s_beats), 32'd24);
    check("blank_gap_count", 32'(gaps.size()), 32'd5);
    for (int i = 0; i < 5 && i < gaps.size(); i++)
      check("blank_gap_len", 32'(gaps[i]), 32'(exp_gaps[i]));
    check("blank_queue_left", 32'(q_s.size()), 32'd0);
    check("blank_tvalid_end", 32'(s_tvalid), 32'd0);

    // Frame table on the 12x12 instance; pattern inputs are disturbed mid-frame
    for (int i = 0; i < 4; i++) begin
      push_frame_l(ftab[i].mode, ftab[i].cval);
      l_mode = 2'(ftab[i].mode);
      l_const = 8'(ftab[i].cval);
      l_rdy_mode = ftab[i].rdy;
      l_enable = 1;
      wait_l_busy("tab_busy");
      l_enable = 0;
      l_mode = 2'(ftab[i].junk);
      l_const = ~8'(ftab[i].cval);
      wait_l_idle("tab_idle");
      check("tab_frame_cnt", 32'(l_frame_cnt), 32'(ftab[i].exp_cnt));
      check("tab_queue_left", 32'(q_l.size()), 32'd0);
    end

    // Mode switch 0 -> 3 mid-frame with continuous enable
    push_frame_l(0, 0);
    push_frame_l(3, 8'h5A);
    l_rdy_mode = 0;
    l_mode = 0;
    l_const = 0;
    base = l_beats;
    l_enable = 1;
    wait_l_beats("modechg_beats20", base + 20);
    l_mode = 3;
    l_const = 8'h5A;
    wait_l_cnt("modechg_cnt5", 5);
    l_enable = 0;
    wait_l_idle("modechg_idle");
    check("modechg_beats", 32'(l_beats - base), 32'd288);
    check("modechg_cnt", 32'(l_frame_cnt), 32'd6);
    check("modechg_queue_left", 32'(q_l.size()), 32'd0);

    // Enable dropped at beat 5 of a frame
    push_frame_l(1, 0);
    l_rdy_mode = 1;
    l_mode = 1;
    base = l_beats;
    l_enable = 1;
    wait_l_beats("endrop_beats5", base + 5);
    l_enable = 0;
    wait_l_idle("endrop_idle");
    check("endrop_beats", 32'(l_beats - base), 32'd144);
    check("endrop_tvalid", 32'(l_tvalid), 32'd0);
    check("endrop_cnt", 32'(l_frame_cnt), 32'd7);
    check("endrop_queue_left", 32'(q_l.size()), 32'd0);

    // Asynchronous reset while stalled mid-line
    l_mon = 0;
    l_rdy_mode = 0;
    l_mode = 1;
    l_enable = 1;
    repeat (8) tick();
    l_rdy_mode = 2;
    repeat (3) tick();
    check("arst_pre_tvalid", 32'(l_tvalid), 32'd1);
    #2;
    l_rst_n = 0;
    #1;
    check("arst_tvalid", 32'(l_tvalid), 32'd0);
    check("arst_tdata",  32'(l_tdata),  32'd0);
    check("arst_tuser",  32'(l_tuser),  32'd0);
    check("arst_tlast",  32'(l_tlast),  32'd0);
    check("arst_cnt",    32'(l_frame_cnt), 32'd0);
    check("arst_busy",   32'(l_busy),   32'd0);
    @(negedge clk);
    l_rst_n = 1;
    l_rdy_mode = 0;
    for (int n = 0; n < 10 && !l_tvalid; n++) tick();
    check("arst_first_tvalid", 32'(l_tvalid), 32'd1);
    check("arst_first_tdata",  32'(l_tdata),  32'h0100);
    check("arst_first_tuser",  32'(l_tuser),  32'd1);
    check("arst_first_cnt",    32'(l_frame_cnt), 32'd0);
    l_enable = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
